// File: rtl/control_reloj_pkg.sv
// Shared types and constants for the digital-clock mode/time-keeping controller.
package control_reloj_pkg;

    localparam int unsigned MODO_W = 3;
    localparam logic [5:0] SEG_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;

    typedef enum logic [MODO_W-1:0] {
        StRun   = 3'd0,
        StSetH  = 3'd1,
        StSetM  = 3'd2,
        StSetAh = 3'd3,
        StSetAm = 3'd4
    } modo_e;

    // Modular increment: max wraps to zero.
    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
        return (v >= max) ? 6'd0 : v + 6'd1;
    endfunction

endpackage

// File: rtl/control_reloj_if.sv
// Button/tick inputs and time/alarm/display outputs of the clock controller.
interface control_reloj_if;
    import control_reloj_pkg::*;

    logic              TICK;
    logic              BTN_MODE;
    logic              BTN_UP;
    logic              BTN_ALM;
    logic [5:0]        HORA;
    logic [5:0]        MIN;
    logic [5:0]        SEG;
    logic [5:0]        AHORA;
    logic [5:0]        AMIN;
    logic              ALARM;
    logic              ALM_EN;
    logic              RING;
    logic [MODO_W-1:0] MODO;

    modport master (
        output TICK, BTN_MODE, BTN_UP, BTN_ALM,
        input  HORA, MIN, SEG, AHORA, AMIN, ALARM, ALM_EN, RING, MODO
    );

    modport slave (
        input  TICK, BTN_MODE, BTN_UP, BTN_ALM,
        output HORA, MIN, SEG, AHORA, AMIN, ALARM, ALM_EN, RING, MODO
    );

endinterface

// File: rtl/control_reloj_detector_flanco.sv
// Rising-edge detector for one debounced button level; one-cycle press pulse.
module control_reloj_detector_flanco (
    input  logic CLK,
    input  logic BTN,
    output logic PULSO
);

    logic prev_q;

    // History follows the level even during reset, so a button held through
    // reset is not seen as a press when reset is released.
    always_ff @(posedge CLK) begin
        prev_q <= BTN;
    end

    assign PULSO = BTN & ~prev_q;

endmodule

// File: rtl/control_reloj.sv
// Clock controller: time/alarm registers, set-mode FSM, alarm match and ring timer.
module control_reloj import control_reloj_pkg::*; #(
    parameter int unsigned RING_SECS = 60,
    parameter int unsigned HOURS     = 24
) (
    input  logic           CLK,
    input  logic           RST,
    control_reloj_if.slave bus
);

    localparam int unsigned     CntW    = $clog2(RING_SECS + 1);
    localparam logic [5:0]      HoraMax = 6'(HOURS - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(RING_SECS - 1);

    modo_e           modo_q, modo_d;
    logic [5:0]      hora_q, hora_d, min_q, min_d, seg_q, seg_d;
    logic [5:0]      ahora_q, ahora_d, amin_q, amin_d;
    logic            alm_en_q, alm_en_d, ring_q, ring_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic p_mode, p_up, p_alm;
    logic consumido, e_mode, e_up, e_alm, cuenta, match;

    control_reloj_detector_flanco u_det_mode (.CLK(CLK), .BTN(bus.BTN_MODE), .PULSO(p_mode));
    control_reloj_detector_flanco u_det_up   (.CLK(CLK), .BTN(bus.BTN_UP),   .PULSO(p_up));
    control_reloj_detector_flanco u_det_alm  (.CLK(CLK), .BTN(bus.BTN_ALM),  .PULSO(p_alm));

    always_comb begin
        modo_d   = modo_q;
        hora_d   = hora_q;
        min_d    = min_q;
        seg_d    = seg_q;
        ahora_d  = ahora_q;
        amin_d   = amin_q;
        alm_en_d = alm_en_q;
        ring_d   = ring_q;
        cnt_d    = cnt_q;

        // While ringing, any press only silences the alarm.
        consumido = ring_q & (p_mode | p_up | p_alm);
        e_mode    = p_mode & ~ring_q;
        e_up      = p_up & ~ring_q & ~p_mode;
        e_alm     = p_alm & ~ring_q;
        cuenta    = bus.TICK & ((modo_q == StRun) | (modo_q == StSetAh) | (modo_q == StSetAm));

        case (modo_q)
            StRun:   if (e_mode) modo_d = StSetH;
            StSetH:  if (e_mode) modo_d = StSetM;
            StSetM:  if (e_mode) modo_d = StSetAh;
            StSetAh: if (e_mode) modo_d = StSetAm;
            StSetAm: if (e_mode) modo_d = StRun;
            default: modo_d = StRun;
        endcase

        if (cuenta) begin
            seg_d = wrap_inc(seg_q, SEG_MAX);
            if (seg_q == SEG_MAX) begin
                min_d = wrap_inc(min_q, MIN_MAX);
                if (min_q == MIN_MAX) hora_d = wrap_inc(hora_q, HoraMax);
            end
        end

        if (e_up) begin
            case (modo_q)
                StSetH:  hora_d  = wrap_inc(hora_q, HoraMax);
                StSetM:  min_d   = wrap_inc(min_q, MIN_MAX);
                StSetAh: ahora_d = wrap_inc(ahora_q, HoraMax);
                StSetAm: amin_d  = wrap_inc(amin_q, MIN_MAX);
                default: ;
            endcase
        end

        if (e_mode && (modo_q == StRun)) seg_d = '0;

        alm_en_d = alm_en_q ^ e_alm;

        if (consumido || e_alm) begin
            ring_d = 1'b0;
        end else if (ring_q && bus.TICK) begin
            if (cnt_q == CntLast) ring_d = 1'b0;
            else                  cnt_d  = cnt_q + 1'b1;
        end

        // Match is judged on the time as it will be after this edge.
        match = (modo_q == StRun) & bus.TICK & (seg_d == 6'd0) & (hora_d == ahora_q) &
                (min_d == amin_q) & alm_en_d;
        if (match) begin
            ring_d = 1'b1;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            modo_q   <= StRun;
            hora_q   <= '0;
            min_q    <= '0;
            seg_q    <= '0;
            ahora_q  <= '0;
            amin_q   <= '0;
            alm_en_q <= 1'b0;
            ring_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            modo_q   <= modo_d;
            hora_q   <= hora_d;
            min_q    <= min_d;
            seg_q    <= seg_d;
            ahora_q  <= ahora_d;
            amin_q   <= amin_d;
            alm_en_q <= alm_en_d;
            ring_q   <= ring_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.HORA   = hora_q;
    assign bus.MIN    = min_q;
    assign bus.SEG    = seg_q;
    assign bus.AHORA  = ahora_q;
    assign bus.AMIN   = amin_q;
    assign bus.ALM_EN = alm_en_q;
    assign bus.RING   = ring_q;
    assign bus.MODO   = modo_q;
    assign bus.ALARM  = (modo_q == StSetAh) | (modo_q == StSetAm);

endmodule

// File: tb/tb_control_reloj.sv
// Directed + randomized bench for control_reloj against a seconds-of-day reference model.
module tb_control_reloj;

    localparam int RingSecs = 3;
    localparam int Hours    = 24;
    localparam int DaySecs  = Hours * 3600;

    logic CLK;
    logic RST;
    bit   lv_m, lv_u, lv_a;
    int   n_vec, n_err;

    // Reference state: time as seconds of day, mode as its ordinal.
    int m_t, m_ah, m_am, m_mode, m_cnt;
    bit m_alm, m_ring, pv_m, pv_u, pv_a;

    control_reloj_if bus ();

    control_reloj #(
        .RING_SECS(RingSecs),
        .HOURS    (Hours)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit t, input bit bm, input bit bu,
                              input bit ba);
        bit pm, pu, pa;
        int h, mi, s, nt;
        pm = bm && !pv_m;
        pu = bu && !pv_u;
        pa = ba && !pv_a;
        pv_m = bm;
        pv_u = bu;
        pv_a = ba;
        if (rst) begin
            m_t = 0; m_ah = 0; m_am = 0; m_mode = 0; m_cnt = 0;
            m_alm = 0; m_ring = 0;
            return;
        end
        if (m_ring && (pm || pu || pa)) begin
            m_ring = 0;
            pm = 0; pu = 0; pa = 0;
        end
        h  = m_t / 3600;
        mi = (m_t / 60) % 60;
        s  = m_t % 60;
        nt = m_t;
        if (t && m_mode != 1 && m_mode != 2) nt = (m_t + 1) % DaySecs;
        if (pu && !pm) begin
            case (m_mode)
                1: nt = ((h + 1) % Hours) * 3600 + mi * 60 + s;
                2: nt = h * 3600 + ((mi + 1) % 60) * 60 + s;
                3: m_ah = (m_ah + 1) % Hours;
                4: m_am = (m_am + 1) % 60;
                default: ;
            endcase
        end
        if (pm && m_mode == 0) nt = nt - nt % 60;
        if (pa) begin
            m_alm  = !m_alm;
            m_ring = 0;
        end else if (m_ring && t) begin
            m_cnt++;
            if (m_cnt >= RingSecs) m_ring = 0;
        end
        if (m_mode == 0 && t && nt % 60 == 0 && nt / 3600 == m_ah &&
            (nt / 60) % 60 == m_am && m_alm) begin
            m_ring = 1;
            m_cnt  = 0;
        end
        if (pm) m_mode = (m_mode + 1) % 5;
        m_t = nt;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".HORA"},   int'(bus.HORA),   m_t / 3600);
        check({tag, ".MIN"},    int'(bus.MIN),    (m_t / 60) % 60);
        check({tag, ".SEG"},    int'(bus.SEG),    m_t % 60);
        check({tag, ".AHORA"},  int'(bus.AHORA),  m_ah);
        check({tag, ".AMIN"},   int'(bus.AMIN),   m_am);
        check({tag, ".MODO"},   int'(bus.MODO),   m_mode);
        check({tag, ".ALARM"},  int'(bus.ALARM),  int'(m_mode == 3 || m_mode == 4));
        check({tag, ".ALM_EN"}, int'(bus.ALM_EN), int'(m_alm));
        check({tag, ".RING"},   int'(bus.RING),   int'(m_ring));
    endtask

    task automatic step(input bit rst, input bit t, input string tag);
        @(negedge CLK);
        RST          = rst;
        bus.TICK     = t;
        bus.BTN_MODE = lv_m;
        bus.BTN_UP   = lv_u;
        bus.BTN_ALM  = lv_a;
        @(posedge CLK);
        model_step(rst, t, lv_m, lv_u, lv_a);
        #1;
        check_all(tag);
    endtask

    // which: 0 = MODE, 1 = UP, 2 = ALM
    task automatic press(input int which, input int n, input string tag);
        repeat (n) begin
            case (which)
                0:       lv_m = 1;
                1:       lv_u = 1;
                default: lv_a = 1;
            endcase
            step(0, 0, tag);
            lv_m = 0; lv_u = 0; lv_a = 0;
            step(0, 0, tag);
        end
    endtask

    task automatic ticks(input int n, input string tag);
        repeat (n) step(0, 1, tag);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        RST = 1'b1;
        bus.TICK = 1'b0;
        lv_m = 1; lv_u = 1; lv_a = 1;
        bus.BTN_MODE = 1'b1;
        bus.BTN_UP   = 1'b1;
        bus.BTN_ALM  = 1'b1;

        // 1: reset with buttons held; release with buttons still held.
        repeat (3) step(1, 0, "t1.rst");
        check("t1.rst_hora", int'(bus.HORA), 0);
        check("t1.rst_modo", int'(bus.MODO), 0);
        check("t1.rst_ring", int'(bus.RING), 0);
        repeat (2) step(0, 0, "t1.hold");
        check("t1.hold_modo", int'(bus.MODO), 0);
        check("t1.hold_almen", int'(bus.ALM_EN), 0);
        lv_m = 0; lv_u = 0; lv_a = 0;
        step(0, 0, "t1.rel");

        // 2: preload 23:59:58, then roll over midnight.
        press(0, 1, "t2.set");
        press(1, 23, "t2.uph");
        press(0, 1, "t2.set");
        press(1, 59, "t2.upm");
        press(0, 3, "t2.run");
        ticks(58, "t2.cnt");
        check("t2.hora", int'(bus.HORA), 23);
        check("t2.min", int'(bus.MIN), 59);
        check("t2.seg58", int'(bus.SEG), 58);
        ticks(1, "t2.t59");
        check("t2.seg59", int'(bus.SEG), 59);
        ticks(1, "t2.wrap");
        check("t2.wrap_hora", int'(bus.HORA), 0);
        check("t2.wrap_min", int'(bus.MIN), 0);
        check("t2.wrap_seg", int'(bus.SEG), 0);

        // 3: hour wraps at 24 in SET_H, ticks ignored there.
        press(0, 1, "t3.seth");
        press(1, 25, "t3.up");
        check("t3.hora", int'(bus.HORA), 1);
        check("t3.modo", int'(bus.MODO), 1);
        ticks(3, "t3.tick");
        check("t3.seg", int'(bus.SEG), 0);
        press(0, 4, "t3.run");

        // 4: alarm 00:01, time 00:00:59, ring for RingSecs ticks.
        press(0, 4, "t4.setam");
        press(1, 1, "t4.upam");
        press(0, 1, "t4.run");
        press(0, 1, "t4.seth");
        press(1, 23, "t4.uph");
        press(0, 4, "t4.run2");
        press(2, 1, "t4.arm");
        check("t4.almen", int'(bus.ALM_EN), 1);
        ticks(59, "t4.cnt");
        check("t4.noring", int'(bus.RING), 0);
        ticks(1, "t4.match");
        check("t4.ring", int'(bus.RING), 1);
        ticks(2, "t4.hold");
        check("t4.ring_hold", int'(bus.RING), 1);
        ticks(1, "t4.expire");
        check("t4.ring_off", int'(bus.RING), 0);

        // 5: a press while ringing only silences.
        press(0, 1, "t5.seth");
        press(1, 24, "t5.uph");
        press(0, 1, "t5.setm");
        press(1, 59, "t5.upm");
        press(0, 3, "t5.run");
        ticks(60, "t5.cnt");
        check("t5.ring", int'(bus.RING), 1);
        press(1, 1, "t5.silence");
        check("t5.ring_off", int'(bus.RING), 0);
        check("t5.min", int'(bus.MIN), 1);
        check("t5.hora", int'(bus.HORA), 0);
        check("t5.modo", int'(bus.MODO), 0);

        // 6: MODE beats UP on the same edge; alarm modes keep time running.
        press(0, 1, "t6.seth");
        lv_m = 1; lv_u = 1;
        step(0, 0, "t6.both");
        check("t6.modo", int'(bus.MODO), 2);
        check("t6.hora", int'(bus.HORA), 0);
        lv_m = 0; lv_u = 0;
        step(0, 0, "t6.rel");
        press(0, 1, "t6.setah");
        check("t6.alarm", int'(bus.ALARM), 1);
        ticks(1, "t6.tick");
        check("t6.seg", int'(bus.SEG), 1);
        press(0, 2, "t6.run");

        // Random phase.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) lv_m = !lv_m;
            if ($urandom_range(0, 2) == 0) lv_u = !lv_u;
            if ($urandom_range(0, 9) == 0) lv_a = !lv_a;
            step(bit'($urandom_range(0, 999) == 0), bit'($urandom_range(0, 1)), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
